// File: rtl/color_event_scheduler.sv
// color_event_scheduler
//   Collects value-change events from NREQ requesters (one pending slot
//   each) and issues them one at a time to the shared color-evaluation
//   engine in round-robin order. It also flags when the network has been
//   quiet for SETTLE consecutive cycles.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester event handshake
//   req_port          4-bit target input index per requester, slice [4i+3:4i]
//   req_data          (BW+1)-bit color vector per requester, slice i
//   out_valid/ready   issue handshake to the engine
//   out_src           granted requester index
//   out_port/out_data port and color vector of the issued event
//   evt_count         saturating count of completed issues
//   settled           no requests, pending events or issued events for SETTLE cycles
//   dbg_settle_state  current state of the settle machine
//
// Handshake rule (both sides): a transfer happens in exactly the cycle where
// valid and ready are both high at the rising edge; valid, once raised by
// this block on the output side, holds its payload stable until ready.
module color_event_scheduler #(
    parameter int  NREQ   = 4,
    parameter int  BW     = 63,
    parameter int  SETTLE = 8,
    localparam int SW     = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [4*NREQ-1:0]      req_port,
    input  logic [(BW+1)*NREQ-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SW-1:0]          out_src,
    output logic [3:0]             out_port,
    output logic [BW:0]            out_data,
    output logic [15:0]            evt_count,
    output logic                   settled,
    output logic [1:0]             dbg_settle_state
);

    typedef enum logic [1:0] {
        S_ACTIVE   = 2'd0,
        S_COUNTING = 2'd1,
        S_SETTLED  = 2'd2
    } settle_state_t;

    // Pending slots
    logic [NREQ-1:0] r_pend;
    logic [3:0]      r_slot_port [NREQ];
    logic [BW:0]     r_slot_data [NREQ];

    // Output register and arbiter pointer
    logic            r_out_valid;
    logic [SW-1:0]   r_out_src;
    logic [3:0]      r_out_port;
    logic [BW:0]     r_out_data;
    logic [SW-1:0]   r_ptr;
    logic [15:0]     r_evt_count;

    // Settle machine
    settle_state_t   r_state;
    settle_state_t   w_state_next;
    logic [7:0]      r_quiet;
    logic [7:0]      w_quiet_next;
    logic            w_activity;

    // Arbiter
    logic            w_load_ok;
    logic            w_found;
    logic            w_grant_any;
    logic [SW-1:0]   w_gidx;
    logic [SW:0]     w_scan;
    logic [NREQ-1:0] w_grant;
    logic [SW-1:0]   w_ptr_next;

    // Round-robin search: first pending slot at or after the pointer.
    always_comb begin
        w_load_ok = ~r_out_valid | out_ready;
        w_found   = 1'b0;
        w_gidx    = '0;
        w_scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (SW+1)'(k);
            if (w_scan >= (SW+1)'(NREQ)) begin
                w_scan = w_scan - (SW+1)'(NREQ);
            end
            if (!w_found && r_pend[w_scan[SW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_scan[SW-1:0];
            end
        end
        w_grant_any = w_load_ok & w_found;
        w_grant     = '0;
        if (w_grant_any) begin
            w_grant[w_gidx] = 1'b1;
        end
        w_ptr_next = (w_gidx == SW'(NREQ-1)) ? '0 : w_gidx + SW'(1);
    end

    // A slot being granted this cycle can take a new event at the same edge.
    assign req_ready = ~r_pend | w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot_port[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // A refill wins over the clear: the old contents leave
                // through the output register at this same edge.
                if (req_valid[i] && req_ready[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_slot_port[i] <= req_port[4*i +: 4];
                    r_slot_data[i] <= req_data[(BW+1)*i +: (BW+1)];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out_port  <= '0;
            r_out_data  <= '0;
            r_ptr       <= '0;
        end else if (w_load_ok) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_src  <= w_gidx;
                r_out_port <= r_slot_port[w_gidx];
                r_out_data <= r_slot_data[w_gidx];
                r_ptr      <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_count <= '0;
        end else if (r_out_valid && out_ready && (r_evt_count != 16'hFFFF)) begin
            r_evt_count <= r_evt_count + 16'd1;
        end
    end

    // Settle machine: any request, pending slot or presented event restarts
    // the quiet count; settled holds while the count sits at SETTLE.
    always_comb begin
        w_activity   = (|req_valid) | (|r_pend) | r_out_valid;
        w_state_next = r_state;
        w_quiet_next = r_quiet;
        if (w_activity) begin
            w_state_next = S_ACTIVE;
            w_quiet_next = '0;
        end else begin
            if (r_quiet != 8'(SETTLE)) begin
                w_quiet_next = r_quiet + 8'd1;
            end
            w_state_next = (w_quiet_next == 8'(SETTLE)) ? S_SETTLED : S_COUNTING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACTIVE;
            r_quiet <= '0;
        end else begin
            r_state <= w_state_next;
            r_quiet <= w_quiet_next;
        end
    end

    assign out_valid        = r_out_valid;
    assign out_src          = r_out_src;
    assign out_port         = r_out_port;
    assign out_data         = r_out_data;
    assign evt_count        = r_evt_count;
    assign settled          = (r_state == S_SETTLED);
    assign dbg_settle_state = r_state;

endmodule

// File: doc/color_event_scheduler.md
# color_event_scheduler

Arbitration and sequencing stage between the per-instance color/flop/blob change sources and the single shared color-evaluation engine. It accepts value-change events from NREQ requesters, holds one pending event per requester, and issues them one at a time to the engine. Issue order is round-robin, through a valid/ready handshake. It also reports when the network has settled, meaning no events are pending or in flight for a programmable number of cycles.

## Interface
- NREQ, 4, number of requesters (2..16)
- BW, 63, color vector MSB index; each vector is BW+1 bits
- SETTLE, 8, quiet cycles required before `settled` asserts (1..255)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  requester i has an event
- req_ready  output  NREQ  requester i event accepted this cycle when valid&ready
- req_port  input  4*NREQ  target input index (0..9) per requester, slice [4i+3:4i]
- req_data  input  (BW+1)*NREQ  color vector per requester, slice i
- out_valid  output  1  event presented to engine
- out_ready  input  1  engine accepts
- out_src  output  SW  granted requester index, SW = max(1,$clog2(NREQ))
- out_port  output  4  port of issued event
- out_data  output  BW+1  color vector of issued event
- evt_count  output  16  issued-event counter
- settled  output  1  network quiet

## Operation
- Per-requester pending slot: pend[i], port, data.
  - req_ready[i] = ~pend[i] | grant[i].
  - On req_valid[i]&req_ready[i], the slot loads and pend[i] is set next cycle.
- Output register: out_valid, out_src, out_port, out_data.
  - load_ok = ~out_valid | out_ready.
- Arbiter is round-robin over pend with pointer ptr.
  - When load_ok and any pend: search ptr, ptr+1, … mod NREQ; the first set bit i is granted.
  - On grant: the output register loads slot i, out_valid=1 next cycle, pend[i] clears unless refilled the same cycle, and ptr = (i+1) mod NREQ.
  - When load_ok and no pend: out_valid=0 next cycle.
  - While out_valid&~out_ready: out_* hold stable and no grant occurs.
- Same-cycle grant and refill of slot i: the new event takes the slot and pend[i] stays 1. The granted event comes from the old slot contents.
- evt_count increments on out_valid&out_ready and saturates at 16'hFFFF.
- Settle state machine (quiet_cnt, 8 bits):
  - ACTIVE: any req_valid, any pend, or out_valid → quiet_cnt=0.
  - COUNTING: none of these → quiet_cnt increments, saturating at SETTLE.
  - settled = (quiet_cnt==SETTLE), registered.
  - Any activity drops settled the next cycle.
- No event is ever dropped or duplicated. The only exception is reset, which discards everything.

## Timing
- Reset values: req_ready all 1 (combinational from pend=0), out_valid=0, out_src=0, out_port=0, out_data=0, evt_count=0, settled=0, ptr=0, all pend=0, quiet_cnt=0.
- Reset mid-operation: everything returns to the reset values the next cycle, and any presented event is abandoned.
- Minimum latency: accept at cycle t → pend at t+1 → out_valid at t+2.
- Throughput: one event per cycle while out_ready=1 and events are pending.
- Worst-case wait for a pending requester: NREQ issues.
- settled: with no further activity after the last handshake at cycle t, settled rises at t+SETTLE+1.

## Test plan
- Single event: reset, req_valid[2]=1, port=5, data=64'hA5 for one cycle.
  - out_valid at +2 with out_src=2, out_port=5, out_data=64'hA5.
  - out_ready=1 → evt_count=1.
  - settled rises SETTLE+1 cycles after the handshake.
- Fairness: all 4 requesters held valid continuously, out_ready=1.
  - Grant order 0,1,2,3,0,1,…
  - Each requester is granted exactly once every 4 issues.
- Backpressure: out_ready=0 for 10 cycles with 4 events pending.
  - out_* stable throughout; req_ready=0 for all full slots.
  - On release, 4 events issue on consecutive cycles in round-robin order.
- Refill on grant: requester 1 pending with data X, grant 1 in the same cycle it presents Y.
  - X issues; Y remains pending; req_ready[1]=1 that cycle; Y issues later.
- Mid-operation reset: rst asserted with 3 events pending and out_valid=1.
  - Next cycle out_valid=0, evt_count=0, settled=0, ptr=0.
  - The next event after reset from requester 3 issues with out_src=3.
- Counter saturation: force 65536 handshakes.
  - evt_count holds at 16'hFFFF.
